hazard_ctrl: RTL and testbench

- Pipeline hazard controller that sequences the IF/ID and ID/EX pipeline registers and the PC.
- Generates PC write-enable, the IF/ID enable (if_id_sel), the IF/ID flush and the ID/EX bubble (flush).
- Handles load-use stalls, taken-branch/jump flushes (multi-cycle when branch resolution is deep) and data-memory busy freezes. A branch that arrives during a freeze is held and applied when the freeze ends.
- Sits beside the datapath; its outputs feed IF_ID, ID_EX and the PC register directly.

---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives PC write, IF/ID load/flush and ID/EX bubble
// from load-use, taken-branch and data-memory-busy conditions.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             if_id_sel,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN = 2'd0, FREEZE = 2'd1, FLUSH = 2'd2} state_t;
    typedef enum logic [1:0] {ACT_NORMAL, ACT_FRZ, ACT_LU, ACT_BR} act_t;

    localparam logic [3:0] FC_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state, w_state_next;
    logic             r_pend_br, w_pend_next;
    logic [3:0]       r_fcnt, w_fcnt_next;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    act_t             w_act;
    logic             w_br_event;
    logic             w_load_use;
    logic             w_pc_we, w_if_id_sel, w_if_id_flush, w_id_ex_flush;

    assign w_load_use = idex_memread && (idex_rt != 5'd0) &&
                        ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

    always_comb begin
        w_state_next = r_state;
        w_pend_next  = r_pend_br;
        w_fcnt_next  = r_fcnt;
        w_act        = ACT_NORMAL;
        w_br_event   = 1'b0;
        case (r_state)
            RUN, FREEZE: begin
                if (mem_busy) begin
                    w_act        = ACT_FRZ;
                    w_pend_next  = (r_state == FREEZE) ? (r_pend_br | ex_branch_taken)
                                                       : ex_branch_taken;
                    w_state_next = FREEZE;
                end else if (ex_branch_taken || (r_state == FREEZE && r_pend_br)) begin
                    w_act        = ACT_BR;
                    w_br_event   = 1'b1;
                    w_pend_next  = 1'b0;
                    w_state_next = RUN;
                    if (FLUSH_CYCLES > 1) begin
                        w_fcnt_next  = FC_RELOAD;
                        w_state_next = FLUSH;
                    end
                end else begin
                    w_act        = w_load_use ? ACT_LU : ACT_NORMAL;
                    w_state_next = RUN;
                end
            end
            FLUSH: begin
                // A branch caught while frozen in FLUSH is kept and restarts the flush window.
                if (mem_busy) begin
                    w_act       = ACT_FRZ;
                    w_pend_next = r_pend_br | ex_branch_taken;
                end else begin
                    w_act = ACT_BR;
                    if (ex_branch_taken || r_pend_br) begin
                        w_br_event  = 1'b1;
                        w_pend_next = 1'b0;
                        w_fcnt_next = FC_RELOAD;
                    end else begin
                        w_fcnt_next = 4'(r_fcnt - 4'd1);
                        if (r_fcnt == 4'd1) w_state_next = RUN;
                    end
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    always_comb begin
        w_pc_we       = 1'b1;
        w_if_id_sel   = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        case (w_act)
            ACT_FRZ: begin
                w_pc_we     = 1'b0;
                w_if_id_sel = 1'b0;
            end
            ACT_LU: begin
                w_pc_we       = 1'b0;
                w_if_id_sel   = 1'b0;
                w_id_ex_flush = 1'b1;
            end
            ACT_BR: begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_we       = ~rst & w_pc_we;
    assign if_id_sel   = ~rst & w_if_id_sel;
    assign if_id_flush = ~rst & w_if_id_flush;
    assign id_ex_flush = ~rst & w_id_ex_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_pend_br   <= 1'b0;
            r_fcnt      <= 4'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pend_br <= w_pend_next;
            r_fcnt    <= w_fcnt_next;
            if (!w_pc_we && r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_br_event && r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign state_o   = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: FLUSH_CYCLES=1, FLUSH_CYCLES=3 and a narrow-counter
// instance share the same input stimulus.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       id_uses_rt, idex_memread, ex_branch_taken, mem_busy;

    logic        u1_pc_we, u1_sel, u1_iff, u1_ief;
    logic [1:0]  u1_state;
    logic [15:0] u1_stall, u1_flush;
    logic        u3_pc_we, u3_sel, u3_iff, u3_ief;
    logic [1:0]  u3_state;
    logic [15:0] u3_stall, u3_flush;
    logic        us_pc_we, us_sel, us_iff, us_ief;
    logic [1:0]  us_state;
    logic [1:0]  us_stall, us_flush;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_we(u1_pc_we), .if_id_sel(u1_sel), .if_id_flush(u1_iff),
        .id_ex_flush(u1_ief), .state_o(u1_state), .stall_cnt(u1_stall), .flush_cnt(u1_flush));

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_we(u3_pc_we), .if_id_sel(u3_sel), .if_id_flush(u3_iff),
        .id_ex_flush(u3_ief), .state_o(u3_state), .stall_cnt(u3_stall), .flush_cnt(u3_flush));

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) us (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .pc_we(us_pc_we), .if_id_sel(us_sel), .if_id_flush(us_iff),
        .id_ex_flush(us_ief), .state_o(us_state), .stall_cnt(us_stall), .flush_cnt(us_flush));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected action as {pc_we, if_id_sel, if_id_flush, id_ex_flush}.
    task automatic act1(input string tag, input logic [3:0] exp);
        chk(tag, 32'({u1_pc_we, u1_sel, u1_iff, u1_ief}), 32'(exp));
    endtask

    task automatic act3(input string tag, input logic [3:0] exp);
        chk(tag, 32'({u3_pc_we, u3_sel, u3_iff, u3_ief}), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs = 5'd0; id_rt = 5'd0; idex_rt = 5'd0;
        id_uses_rt = 1'b0; idex_memread = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    // Pulse the asynchronous reset between clock edges.
    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    localparam logic [3:0] NORMAL = 4'b1100;
    localparam logic [3:0] FRZ    = 4'b0000;
    localparam logic [3:0] LU     = 4'b0001;
    localparam logic [3:0] BR     = 4'b1111;

    initial begin
        rst = 1'b1;
        clear_in();
        id_rs = 5'd5; idex_rt = 5'd5; idex_memread = 1'b1;
        #12;
        act1("reset_outputs", 4'b0000);
        chk("reset_state", 32'(u1_state), 0);
        chk("reset_stall", 32'(u1_stall), 0);
        clear_in();
        rst = 1'b0;
        #1;
        act1("normal_after_reset", NORMAL);
        step();
        $display("step: reset and normal run checked");

        idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
        #1 act1("load_use_rs", LU);
        step();
        clear_in();
        #1 act1("after_load_use", NORMAL);
        chk("stall_cnt_lu", 32'(u1_stall), 1);
        $display("step: load-use on rs checked");

        idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
        #1 act1("load_use_r0", NORMAL);
        step();
        id_rs = 5'd0; id_rt = 5'd5; idex_rt = 5'd5; id_uses_rt = 1'b0;
        #1 act1("rt_not_used", NORMAL);
        step();
        chk("stall_cnt_unchanged", 32'(u1_stall), 1);
        id_uses_rt = 1'b1;
        #1 act1("load_use_rt", LU);
        step();
        clear_in();
        #1 chk("stall_cnt_rt", 32'(u1_stall), 2);
        $display("step: load-use on $0 and rt checked");

        ex_branch_taken = 1'b1;
        #1 act1("branch_fc1", BR);
        step();
        clear_in();
        #1 act1("after_branch_fc1", NORMAL);
        chk("flush_cnt_fc1", 32'(u1_flush), 1);
        chk("state_fc1", 32'(u1_state), 0);
        $display("step: single-cycle branch flush checked");

        pulse_rst();
        mem_busy = 1'b1;
        #1 act1("freeze_c1", FRZ);
        step();
        chk("state_freeze", 32'(u1_state), 1);
        ex_branch_taken = 1'b1;
        #1 act1("freeze_c2_branch", FRZ);
        step();
        ex_branch_taken = 1'b0;
        #1 act1("freeze_c3", FRZ);
        step();
        mem_busy = 1'b0;
        #1 act1("held_branch", BR);
        step();
        #1 act1("after_held_branch", NORMAL);
        chk("state_after_freeze", 32'(u1_state), 0);
        chk("stall_cnt_freeze", 32'(u1_stall), 3);
        chk("flush_cnt_freeze", 32'(u1_flush), 1);
        chk("sat_stall_at_max", 32'(us_stall), 3);
        idex_memread = 1'b1; idex_rt = 5'd7; id_rs = 5'd7;
        step();
        clear_in();
        #1 chk("stall_cnt_4", 32'(u1_stall), 4);
        chk("sat_stall_held", 32'(us_stall), 3);
        $display("step: branch held across freeze and counter saturation checked");

        pulse_rst();
        ex_branch_taken = 1'b1;
        #1 act3("fc3_br1", BR);
        step();
        ex_branch_taken = 1'b0;
        chk("fc3_state_flush", 32'(u3_state), 2);
        mem_busy = 1'b1;
        #1 act3("fc3_frz", FRZ);
        step();
        mem_busy = 1'b0;
        #1 act3("fc3_br2", BR);
        step();
        #1 act3("fc3_br3", BR);
        step();
        #1 act3("fc3_done", NORMAL);
        chk("fc3_state_run", 32'(u3_state), 0);
        chk("fc3_flush_cnt", 32'(u3_flush), 1);
        chk("fc3_stall_cnt", 32'(u3_stall), 1);
        $display("step: multi-cycle flush with freeze checked");

        ex_branch_taken = 1'b1;
        step();
        ex_branch_taken = 1'b0;
        #1 act3("fc3_mid_flush", BR);
        rst = 1'b1;
        #1 act3("async_rst_outputs", 4'b0000);
        chk("async_rst_state", 32'(u3_state), 0);
        #2 rst = 1'b0;
        #1 act3("post_rst_normal", NORMAL);
        chk("post_rst_state", 32'(u3_state), 0);
        chk("post_rst_flush_cnt", 32'(u3_flush), 0);
        chk("post_rst_stall_cnt", 32'(u3_stall), 0);
        step();
        #1 act3("post_rst_no_residual", NORMAL);
        $display("step: asynchronous reset mid-flush checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
